// File: rtl/counter_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_pkg
// Brief    : Shared state encoding and mode constants for counter_seq_ctrl.
// Revision : 1.0
// ============================================================================
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/counter_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_ctrl_if
// Brief    : Command and count bus between control logic and the sequencer.
// Revision : 1.0
// ============================================================================
interface counter_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int PS_W  = 4
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] tc;
    logic [PS_W-1:0]  prescale;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tc_pulse;

    modport master (
        output start, stop, mode, tc, prescale,
        input  count, busy, done, tc_pulse
    );

    modport slave (
        input  start, stop, mode, tc, prescale,
        output count, busy, done, tc_pulse
    );
endinterface
`default_nettype wire

// File: rtl/counter_seq_ctrl_up_counter_en.sv
`default_nettype none
// ============================================================================
// Module   : up_counter_en
// Brief    : WIDTH-bit up counter with enable, synchronous clear and wrap.
// Revision : 1.0
// ============================================================================
module up_counter_en #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             en,
    input  wire logic             clr,
    input  wire logic             wrap,
    output logic      [WIDTH-1:0] count
);
    logic [WIDTH-1:0] r_count;

    // Clear dominates wrap, which dominates a plain increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr || wrap) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_ctrl
// Brief    : Start/stop/pause sequencer with prescaler and terminal count.
// Revision : 1.0
// ============================================================================
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PS_W  = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    counter_seq_ctrl_if.slave bus
);
    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_tc;
    logic             r_mode;
    logic [PS_W-1:0]  r_prescale;
    logic [PS_W-1:0]  r_pre_cnt;
    logic             r_tc_pulse;
    logic [WIDTH-1:0] w_count;
    logic             w_strobe;
    logic             w_terminal;
    logic             w_latch;
    logic             w_clr;
    logic             w_en;
    logic             w_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_clr        = 1'b0;
        w_en         = 1'b0;
        w_wrap       = 1'b0;
        w_strobe     = (r_state == RUN) && !bus.stop && (r_pre_cnt == '0);
        w_terminal   = w_strobe && (w_count == r_tc);
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_latch      = 1'b1;
                    w_clr        = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    w_next_state = HOLD;
                end else if (w_terminal) begin
                    if (r_mode == MODE_PERIODIC) begin
                        w_wrap = 1'b1;
                    end else begin
                        w_next_state = DONE;
                    end
                end else if (w_strobe) begin
                    w_en = 1'b1;
                end
            end
            HOLD: begin
                if (bus.stop) begin
                    w_clr        = 1'b1;
                    w_next_state = IDLE;
                end else if (bus.start) begin
                    w_next_state = RUN;
                end
            end
            DONE: begin
                if (bus.stop) begin
                    w_clr        = 1'b1;
                    w_next_state = IDLE;
                end else if (bus.start) begin
                    w_latch      = 1'b1;
                    w_clr        = 1'b1;
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Prescaler only moves while running; HOLD leaves it exactly where it stopped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tc       <= '0;
            r_mode     <= MODE_ONESHOT;
            r_prescale <= '0;
            r_pre_cnt  <= '0;
            r_tc_pulse <= 1'b0;
        end else begin
            r_tc_pulse <= w_terminal;
            if (w_latch) begin
                r_tc       <= bus.tc;
                r_mode     <= bus.mode;
                r_prescale <= bus.prescale;
                r_pre_cnt  <= bus.prescale;
            end else if ((r_state == RUN) && !bus.stop) begin
                if (r_pre_cnt == '0) begin
                    r_pre_cnt <= r_prescale;
                end else begin
                    r_pre_cnt <= r_pre_cnt - PS_W'(1);
                end
            end
        end
    end

    up_counter_en #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .clr   (w_clr),
        .wrap  (w_wrap),
        .count (w_count)
    );

    assign bus.count    = w_count;
    assign bus.busy     = (r_state == RUN) || (r_state == HOLD);
    assign bus.done     = (r_state == DONE);
    assign bus.tc_pulse = r_tc_pulse;
endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_seq_ctrl
// Brief    : Directed self-checking bench for counter_seq_ctrl.
// Revision : 1.0
// ============================================================================
module tb_counter_seq_ctrl;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    counter_seq_ctrl_if #(.WIDTH(4), .PS_W(4)) bus ();

    counter_seq_ctrl #(
        .WIDTH (4),
        .PS_W  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; outputs and inputs are handled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic m, input logic [3:0] t, input logic [3:0] p);
        bus.start    = 1'b1;
        bus.mode     = m;
        bus.tc       = t;
        bus.prescale = p;
        step(1);
        bus.start    = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.count, bus.busy, bus.done, bus.tc_pulse} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got count=%0d busy=%b done=%b tcp=%b, need all 0",
                     bus.count, bus.busy, bus.done, bus.tc_pulse);
        end
    endtask

    task automatic test_periodic();
        do_start(1'b1, 4'd3, 4'd0);
        checks++;
        if (bus.count !== 4'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL periodic_start: got count=%0d busy=%b, need 0/1", bus.count, bus.busy);
        end
        // Latched fields must ignore later input changes.
        bus.tc = 4'd9; bus.prescale = 4'd5; bus.mode = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step(1);
            checks++;
            if (bus.count !== 4'(j % 4) || bus.tc_pulse !== (j % 4 == 0) || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL periodic_seq j=%0d: got count=%0d tcp=%b busy=%b, need %0d/%b/1",
                         j, bus.count, bus.tc_pulse, bus.busy, j % 4, (j % 4 == 0));
            end
        end
        do_stop();
        do_stop();
        checks++;
        if (bus.count !== 4'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL periodic_stop_idle: got count=%0d busy=%b, need 0/0", bus.count, bus.busy);
        end
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_cnt;
        do_start(1'b0, 4'd5, 4'd2);
        for (int j = 1; j <= 19; j++) begin
            step(1);
            exp_cnt = (j < 18) ? 4'(j / 3) : 4'd5;
            checks++;
            if (bus.count !== exp_cnt || bus.tc_pulse !== (j == 18) ||
                bus.done !== (j >= 18) || bus.busy !== (j < 18)) begin
                errors++;
                $display("FAIL oneshot_seq j=%0d: got count=%0d tcp=%b done=%b busy=%b, need %0d/%b/%b/%b",
                         j, bus.count, bus.tc_pulse, bus.done, bus.busy,
                         exp_cnt, (j == 18), (j >= 18), (j < 18));
            end
        end
        step(5);
        checks++;
        if (bus.count !== 4'd5 || bus.done !== 1'b1 || bus.tc_pulse !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_hold: got count=%0d done=%b tcp=%b, need 5/1/0",
                     bus.count, bus.done, bus.tc_pulse);
        end
        do_stop();
        checks++;
        if (bus.count !== 4'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_stop: got count=%0d done=%b, need 0/0", bus.count, bus.done);
        end
    endtask

    task automatic test_hold();
        do_start(1'b1, 4'd7, 4'd1);
        step(4);
        checks++;
        if (bus.count !== 4'd2) begin
            errors++;
            $display("FAIL hold_pre: got count=%0d, need 2", bus.count);
        end
        do_stop();
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (bus.count !== 4'd2 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_frozen j=%0d: got count=%0d busy=%b, need 2/1", j, bus.count, bus.busy);
            end
            step(1);
        end
        // pre_cnt was 1 when paused: one decrement, then the strobe.
        do_start(1'b0, 4'd0, 4'd0);
        step(1);
        checks++;
        if (bus.count !== 4'd2) begin
            errors++;
            $display("FAIL resume_first: got count=%0d, need 2", bus.count);
        end
        step(1);
        checks++;
        if (bus.count !== 4'd3) begin
            errors++;
            $display("FAIL resume_strobe: got count=%0d, need 3", bus.count);
        end
        step(2);
        checks++;
        if (bus.count !== 4'd4 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL resume_no_relatch: got count=%0d done=%b, need 4/0", bus.count, bus.done);
        end
        do_stop();
        do_stop();
        checks++;
        if (bus.count !== 4'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_to_idle: got count=%0d busy=%b, need 0/0", bus.count, bus.busy);
        end
    endtask

    task automatic test_both();
        bus.start = 1'b1; bus.stop = 1'b1; bus.mode = 1'b1; bus.tc = 4'd7; bus.prescale = 4'd0;
        step(2);
        bus.start = 1'b0; bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.count !== 4'd0) begin
            errors++;
            $display("FAIL both_idle: got busy=%b count=%0d, need 0/0", bus.busy, bus.count);
        end
        do_start(1'b1, 4'd7, 4'd0);
        step(2);
        bus.start = 1'b1; bus.stop = 1'b1;
        step(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        step(2);
        checks++;
        if (bus.busy !== 1'b1 || bus.count !== 4'd2) begin
            errors++;
            $display("FAIL both_run_hold: got busy=%b count=%0d, need 1/2", bus.busy, bus.count);
        end
        do_stop();
        // tc=0 one-shot: terminal on the very first strobe.
        do_start(1'b0, 4'd0, 4'd0);
        step(1);
        checks++;
        if (bus.tc_pulse !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 4'd0) begin
            errors++;
            $display("FAIL tc0_oneshot: got tcp=%b done=%b busy=%b count=%0d, need 1/1/0/0",
                     bus.tc_pulse, bus.done, bus.busy, bus.count);
        end
        bus.start = 1'b1; bus.stop = 1'b1;
        step(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tc_pulse !== 1'b0) begin
            errors++;
            $display("FAIL both_done_idle: got done=%b busy=%b tcp=%b, need 0/0/0",
                     bus.done, bus.busy, bus.tc_pulse);
        end
        do_start(1'b0, 4'd0, 4'd0);
        step(1);
        // Restart from DONE re-latches a new periodic configuration.
        do_start(1'b1, 4'd1, 4'd0);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.count !== 4'd0) begin
            errors++;
            $display("FAIL done_restart: got done=%b busy=%b count=%0d, need 0/1/0",
                     bus.done, bus.busy, bus.count);
        end
        step(2);
        checks++;
        if (bus.tc_pulse !== 1'b1 || bus.count !== 4'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL done_restart_wrap: got tcp=%b count=%0d busy=%b, need 1/0/1",
                     bus.tc_pulse, bus.count, bus.busy);
        end
        do_stop();
        do_stop();
    endtask

    task automatic test_tc15();
        do_start(1'b1, 4'd15, 4'd0);
        for (int j = 1; j <= 17; j++) begin
            step(1);
            checks++;
            if (bus.count !== 4'(j % 16) || bus.tc_pulse !== (j == 16)) begin
                errors++;
                $display("FAIL tc15_seq j=%0d: got count=%0d tcp=%b, need %0d/%b",
                         j, bus.count, bus.tc_pulse, j % 16, (j == 16));
            end
        end
        do_stop();
        do_stop();
    endtask

    task automatic test_async_reset();
        do_start(1'b1, 4'd3, 4'd0);
        step(3);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.count, bus.busy, bus.done, bus.tc_pulse} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d busy=%b done=%b tcp=%b, need all 0",
                     bus.count, bus.busy, bus.done, bus.tc_pulse);
        end
        step(2);
        reset = 1'b1;
        step(3);
        checks++;
        if (bus.busy !== 1'b0 || bus.count !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b count=%0d, need 0/0", bus.busy, bus.count);
        end
        do_start(1'b1, 4'd3, 4'd0);
        step(1);
        checks++;
        if (bus.busy !== 1'b1 || bus.count !== 4'd1) begin
            errors++;
            $display("FAIL post_reset_start: got busy=%b count=%0d, need 1/1", bus.busy, bus.count);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
        bus.tc = 4'd0; bus.prescale = 4'd0;
        step(2);
        test_reset();
        reset = 1'b1;
        step(1);
        test_reset();
        test_periodic();
        test_oneshot();
        test_hold();
        test_both();
        test_tc15();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
